// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bridge_pkg
//  Purpose  : Shared types and default constants for the UART register bridge:
//             FSM state encoding, default command/response bytes, timeout
//             default and a saturating-increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    BUS_WR   = 3'd3,
    BUS_RD   = 3'd4,
    RD_CAP   = 3'd5,
    TX_SEND  = 3'd6,
    TX_WAIT  = 3'd7
  } state_e;

  localparam logic [7:0]  DEF_CMD_WRITE      = 8'h57;  // 'W'
  localparam logic [7:0]  DEF_CMD_READ       = 8'h52;  // 'R'
  localparam logic [7:0]  DEF_RSP_ACK        = 8'h4B;  // 'K'
  localparam logic [7:0]  DEF_RSP_NAK        = 8'h3F;  // '?'
  localparam logic [19:0] DEF_TIMEOUT_CYCLES = 20'd500000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bridge_timer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bridge_timer
//  Purpose  : 20-bit clearable up-counter with enable and a terminal-count
//             flag used to detect stalled frames.
//  Ports    : clk, resetn (sync, active-low)
//             en_i   - count this cycle
//             clr_i  - force count to zero (has priority over en_i)
//             tc_o   - high while enabled, not cleared, at count TERMINAL-1
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bridge_timer #(
  parameter logic [19:0] TERMINAL = 20'd500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [19:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + 20'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // A clear on the terminal cycle (incoming byte) suppresses the flag.
  assign tc_o = en_i && !clr_i && (count_q == TERMINAL - 20'd1);

endmodule
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_bridge
//  Purpose  : Parses 'W addr data' / 'R addr' frames from a UART receiver,
//             issues single-cycle register strobes and returns a one-byte
//             response (ACK, read data or NAK) through the UART transmitter.
//  Ports    : clk, resetn          clock, sync active-low reset
//             rx_data/rx_valid     received byte stream
//             tx_data/tx_start     response byte and transmit-load pulse
//             tx_busy              transmitter busy
//             reg_addr/reg_wdata   register bus address / write data
//             reg_we/reg_re        one-cycle write / read strobes
//             reg_rdata            read data, valid the cycle after reg_re
//             frame_timeout        pulse when a frame is abandoned
//             drop_count           saturating count of discarded bytes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [7:0]  CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ       = DEF_CMD_READ,
  parameter logic [7:0]  RSP_ACK        = DEF_RSP_ACK,
  parameter logic [7:0]  RSP_NAK        = DEF_RSP_NAK,
  parameter logic [19:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_timeout,
  output logic [7:0] drop_count
);

  state_e     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       timeout_q, timeout_d;
  logic [7:0] drop_q, drop_d;

  logic       tmr_en, tmr_clr, tmr_tc;

  // Timer only runs while waiting for frame payload; anywhere else it is held
  // at zero so that entry into GET_ADDR/GET_DATA always starts from zero.
  assign tmr_en  = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign tmr_clr = rx_valid || !tmr_en;

  uart_bridge_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (tmr_en),
    .clr_i  (tmr_clr),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    drop_d      = drop_q;
    tx_start_d  = 1'b0;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    timeout_d   = 1'b0;

    // tx_start is registered, so it is decided one cycle ahead: it rises in
    // the first TX_SEND cycle when the transmitter was idle the cycle before,
    // and the FSM leaves TX_SEND in the cycle the pulse is visible.
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = GET_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = GET_ADDR;
          end else begin
            tx_data_d  = RSP_NAK;
            tx_start_d = !tx_busy;
            state_d    = TX_SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_valid) begin
          reg_addr_d = rx_data;
          if (is_wr_q) begin
            state_d = GET_DATA;
          end else begin
            reg_re_d = 1'b1;
            state_d  = BUS_RD;
          end
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
          state_d     = BUS_WR;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      BUS_WR: begin
        tx_data_d  = RSP_ACK;
        tx_start_d = !tx_busy;
        state_d    = TX_SEND;
      end
      BUS_RD: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        tx_data_d  = reg_rdata;
        tx_start_d = !tx_busy;
        state_d    = TX_SEND;
      end
      TX_SEND: begin
        if (tx_start_q)
          state_d = TX_WAIT;
        else
          tx_start_d = !tx_busy;
      end
      TX_WAIT: begin
        if (!tx_busy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while a response is in progress are discarded.
    if (rx_valid && (state_q != IDLE) && (state_q != GET_ADDR) && (state_q != GET_DATA))
      drop_d = sat_inc8(drop_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_re        = reg_re_q;
  assign frame_timeout = timeout_q;
  assign drop_count    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_reg_bridge
//  Purpose  : Directed, table-driven self-checking bench for uart_reg_bridge
//             with a small transmitter-busy model and register read model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_timeout;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  uart_reg_bridge #(
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .frame_timeout (frame_timeout),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    int         we_lat, re_lat, tx_lat;   // 0 = strobe must not occur
    logic [7:0] e_addr, e_wdata, e_tx;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;
  int we_cnt, re_cnt, ts_cnt, ft_cnt;
  int hold_busy = 0;
  int busy_left = 0;
  logic [7:0] exp_drop = 8'h00;

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    case (a)
      8'h22:   return 8'h3C;
      8'h01:   return 8'hA1;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs change and outputs are observed 1 time unit after the
  // rising edge. The transmitter model raises tx_busy the cycle after it
  // samples tx_start and keeps it for two cycles; hold_busy forces it high.
  task automatic step();
    logic st;
    st = tx_start;
    @(posedge clk);
    #1;
    if (st) busy_left = 2;
    if (hold_busy > 0) hold_busy--;
    tx_busy = (hold_busy > 0) || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    reg_rdata = rd_model(reg_addr);
    if (reg_we) we_cnt++;
    if (reg_re) re_cnt++;
    if (tx_start) ts_cnt++;
    if (frame_timeout) ft_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic zero_counts();
    we_cnt = 0; re_cnt = 0; ts_cnt = 0; ft_cnt = 0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int we_l, re_l, tx_l;
    logic [7:0] txd;
    we_l = 0; re_l = 0; tx_l = 0; txd = 8'h00;
    zero_counts();
    send_byte(v.b0);
    if (v.nb > 1) send_byte(v.b1);
    if (v.nb > 2) send_byte(v.b2);
    for (int k = 1; k <= 12; k++) begin
      if (reg_we && we_l == 0) we_l = k;
      if (reg_re && re_l == 0) re_l = k;
      if (tx_start && tx_l == 0) begin
        tx_l = k;
        txd  = tx_data;
      end
      step();
    end
    for (int k = 0; k < 6; k++) step();
    check($sformatf("%s we_lat", tag), we_l, v.we_lat);
    check($sformatf("%s re_lat", tag), re_l, v.re_lat);
    check($sformatf("%s tx_lat", tag), tx_l, v.tx_lat);
    check($sformatf("%s tx_data", tag), txd, v.e_tx);
    check($sformatf("%s we_cnt", tag), we_cnt, (v.we_lat != 0) ? 1 : 0);
    check($sformatf("%s re_cnt", tag), re_cnt, (v.re_lat != 0) ? 1 : 0);
    check($sformatf("%s ts_cnt", tag), ts_cnt, 1);
    check($sformatf("%s reg_addr", tag), reg_addr, v.e_addr);
    check($sformatf("%s reg_wdata", tag), reg_wdata, v.e_wdata);
    check($sformatf("%s drop", tag), drop_count, exp_drop);
    check($sformatf("%s ft_cnt", tag), ft_cnt, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s tx_data", tag), tx_data, 8'h00);
    check($sformatf("%s tx_start", tag), tx_start, 1'b0);
    check($sformatf("%s reg_addr", tag), reg_addr, 8'h00);
    check($sformatf("%s reg_wdata", tag), reg_wdata, 8'h00);
    check($sformatf("%s reg_we", tag), reg_we, 1'b0);
    check($sformatf("%s reg_re", tag), reg_re, 1'b0);
    check($sformatf("%s frame_timeout", tag), frame_timeout, 1'b0);
    check($sformatf("%s drop", tag), drop_count, 8'h00);
  endtask

  initial begin
    int tx_l, ft_l, viol, bad;
    vec_t v;

    //           b0     b1     b2    nb we re tx  addr   wdata  tx
    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 1, 0, 2, 8'h10, 8'hA5, 8'h4B};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 0, 1, 3, 8'h22, 8'hA5, 8'h3C};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 8'h22, 8'hA5, 8'h3F};
    vecs[3] = '{8'h52, 8'h01, 8'h00, 2, 0, 1, 3, 8'h01, 8'hA5, 8'hA1};
    vecs[4] = '{8'h57, 8'hFF, 8'h00, 3, 1, 0, 2, 8'hFF, 8'h00, 8'h4B};
    vecs[5] = '{8'h52, 8'hFF, 8'h00, 2, 0, 1, 3, 8'hFF, 8'h00, 8'hA5};
    vecs[6] = '{8'h4B, 8'h00, 8'h00, 1, 0, 0, 1, 8'hFF, 8'h00, 8'h3F};

    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_busy = 1'b0; reg_rdata = 8'h00;
    zero_counts();
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset");
    resetn = 1'b1;
    step();

    // Table of complete frames.
    for (int i = 0; i < 7; i++)
      apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Busy transmitter: tx_busy high for 40 observed cycles after the data byte.
    zero_counts();
    send_byte(8'h57);
    send_byte(8'h10);
    hold_busy = 41;
    send_byte(8'hA5);
    tx_l = 0; viol = 0; bad = 0;
    for (int k = 1; k <= 60; k++) begin
      if (tx_busy && tx_start) viol++;
      if (k >= 2 && tx_l == 0 && tx_data !== 8'h4B) bad++;
      if (tx_start && tx_l == 0) tx_l = k;
      step();
    end
    check("busy tx_lat", tx_l, 42);
    check("busy overlap", viol, 0);
    check("busy tx_data stable", bad, 0);
    check("busy we_cnt", we_cnt, 1);
    check("busy ts_cnt", ts_cnt, 1);

    // Timeout after a lone write command.
    zero_counts();
    send_byte(8'h57);
    ft_l = 0;
    for (int k = 1; k <= 130; k++) begin
      if (frame_timeout && ft_l == 0) ft_l = k;
      step();
    end
    check("timeout lat", ft_l, 101);
    check("timeout ft_cnt", ft_cnt, 1);
    check("timeout we_cnt", we_cnt, 0);
    check("timeout re_cnt", re_cnt, 0);
    check("timeout ts_cnt", ts_cnt, 0);
    apply_vec(vecs[0], "post-timeout");

    // Byte arriving exactly on the terminal-count cycle wins.
    zero_counts();
    send_byte(8'h57);
    for (int k = 0; k < 99; k++) step();
    send_byte(8'h33);
    send_byte(8'h44);
    for (int k = 0; k < 20; k++) step();
    check("tc-race ft_cnt", ft_cnt, 0);
    check("tc-race we_cnt", we_cnt, 1);
    check("tc-race reg_addr", reg_addr, 8'h33);
    check("tc-race reg_wdata", reg_wdata, 8'h44);
    check("tc-race ts_cnt", ts_cnt, 1);

    // Overrun: bytes during TX_WAIT are dropped and the count saturates.
    zero_counts();
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hA5);
    step();
    check("overrun tx_start", tx_start, 1'b1);
    hold_busy = 1000;
    step();
    for (int i = 0; i < 300; i++) begin
      send_byte(i[7:0]);
      step();
      if (i == 9)   check("drop after 10", drop_count, 8'h0A);
      if (i == 254) check("drop after 255", drop_count, 8'hFF);
    end
    check("drop after 300", drop_count, 8'hFF);
    check("overrun we_cnt", we_cnt, 1);
    check("overrun re_cnt", re_cnt, 0);
    check("overrun ts_cnt", ts_cnt, 1);
    exp_drop = 8'hFF;
    hold_busy = 0;
    for (int k = 0; k < 5; k++) step();

    // Reset while waiting for the data byte.
    zero_counts();
    send_byte(8'h57);
    send_byte(8'h10);
    resetn = 1'b0;
    step();
    check_reset_outputs("midframe-reset");
    resetn = 1'b1;
    exp_drop = 8'h00;
    for (int k = 0; k < 10; k++) step();
    check("midframe we_cnt", we_cnt, 0);
    check("midframe ts_cnt", ts_cnt, 0);
    v = vecs[1];
    v.e_wdata = 8'h00;
    apply_vec(v, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command responder that sits behind the UART core and turns the received byte stream into register-bus accesses. It parses fixed-format write and read frames from the UART receiver, issues single-cycle register strobes, and sends a one-byte response back through the UART transmitter. It gives host software register access over the serial link with no processor in the FPGA.

## Interface
Parameters:
- CMD_WRITE, 8'h57, command byte for a write frame ('W').
- CMD_READ, 8'h52, command byte for a read frame ('R').
- RSP_ACK, 8'h4B, response byte sent after a write ('K').
- RSP_NAK, 8'h3F, response byte sent for an unknown command ('?').
- TIMEOUT_CYCLES, 20'd500000, maximum clk cycles allowed between bytes inside a frame; must be ≥ 2.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle pulse, new received byte
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse, load tx_data into the transmitter
- tx_busy  in  1  transmitter busy; goes high the cycle after tx_start is sampled
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_re
- frame_timeout  out  1  one-cycle pulse when a frame is aborted by timeout
- drop_count  out  8  saturating count of bytes discarded while not accepting input

## Operation
- Write frame: CMD_WRITE, addr, data. Response: RSP_ACK.
- Read frame: CMD_READ, addr. Response: the byte reg_rdata[addr].
- Any other first byte: respond RSP_NAK, then return to IDLE. The byte is not counted as dropped.
- FSM states:
  - IDLE: on rx_valid, decode the byte. WRITE/READ → GET_ADDR. Unknown → load tx_data=RSP_NAK, → TX_SEND.
  - GET_ADDR: on rx_valid, latch reg_addr. For a write → GET_DATA; for a read → BUS_RD.
  - GET_DATA: on rx_valid, latch reg_wdata, → BUS_WR.
  - BUS_WR: reg_we=1 for one cycle; load tx_data=RSP_ACK; → TX_SEND.
  - BUS_RD: reg_re=1 for one cycle; → RD_CAP.
  - RD_CAP: tx_data ← reg_rdata; → TX_SEND.
  - TX_SEND: when tx_busy=0, pulse tx_start and → TX_WAIT. Otherwise hold.
  - TX_WAIT: hold until tx_busy=0, then → IDLE. The first TX_WAIT cycle always sees tx_busy=1.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA. It clears on every rx_valid and on entry to those states.
  - When count = TIMEOUT_CYCLES-1 with no rx_valid: go to IDLE, pulse frame_timeout, send no response, leave the register bus untouched.
- Dropped bytes: any rx_valid in BUS_WR, BUS_RD, RD_CAP, TX_SEND or TX_WAIT is discarded and drop_count increments. drop_count saturates at 8'hFF and clears only on reset.
- reg_addr, reg_wdata and tx_data hold their values until they are next loaded.

## Timing
- Reset (resetn=0 at a clk edge) forces:
  - state IDLE
  - tx_data, reg_addr, reg_wdata = 8'h00
  - tx_start, reg_we, reg_re, frame_timeout = 0
  - drop_count = 0, timeout counter = 0
- Reset mid-frame or mid-response aborts silently. A transmission already started completes inside the UART core.
- Write: data byte's rx_valid at cycle N → reg_we high at N+1 → tx_start at N+2 if tx_busy=0.
- Read: addr byte's rx_valid at cycle N → reg_re at N+1 → reg_rdata sampled at N+2 → tx_start at N+3 if tx_busy=0.
- NAK: rx_valid at N → tx_start at N+1 if tx_busy=0.
- tx_data is stable from the TX_SEND entry cycle until the next frame's load.
- rx_valid on the same cycle as the timeout terminal count: the byte wins and the counter clears. No timeout occurs.
- All outputs are registered.

## Structure
- Package uart_bridge_pkg holds:
  - the state enum (IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, TX_SEND, TX_WAIT)
  - the default command and response constants
- Sub-module uart_bridge_timer: a 20-bit clearable counter with enable, clear and a terminal-count pulse. It is instantiated once.

## Test plan
- Write: send 57 10 A5 → one reg_we with addr 10, wdata A5 at N+1 → tx_start with tx_data 4B at N+2 → drop_count stays 0.
- Read: reg_rdata model returns 3C for addr 22; send 52 22 → one reg_re at N+1 → tx_data 3C with tx_start at N+3.
- Busy transmitter: hold tx_busy=1 for 40 cycles after a write frame → tx_start is held off until the first cycle with tx_busy=0, and tx_data=4B is stable throughout.
- Unknown command: send 00 → response 3F; no reg_we or reg_re; the next frame 52 01 is processed normally.
- Timeout: TIMEOUT_CYCLES=100; send 57 then idle 100 cycles → frame_timeout pulses once, no strobe, no response. A new 57 10 A5 frame then succeeds.
- Overrun and reset: inject 300 rx_valid pulses during TX_WAIT → drop_count=FF. Assert resetn=0 in GET_DATA → all outputs return to reset values and no reg_we fires.
